wave_interp_lookup: RTL and testbench
=====================================

// Module: wave_interp_lookup
// PURPOSE
//  Successor of the 64-entry half-mirror phase-to-sample stage. Converts an NCO phase into an
//  oscillator sample through an external wavetable ROM. Symmetry mode (full/half/quarter) is
//  selectable at run time, and table/phase/sample widths are parametrised. Adds linear
//  interpolation between adjacent table points using the fractional phase bits. Sits between
//  the NCO phase accumulator and the voice mixer; one lookup per START, run at sample rate.
// PARAMETERS
//  PHASE_W   16  phase input width; must be >= ADDR_W+2+FRAC_W
//  ADDR_W    6   table address width (2^ADDR_W entries per program)
//  FRAC_W    8   fractional phase bits used for interpolation
//  SAMPLE_W  8   sample width, unsigned offset-binary
//  PROG_W    7   program (wavetable) select width
// PORTS
//  CLK        in   1                 clock
//  RST        in   1                 asynchronous reset, active-high
//  START      in   1                 request lookup; honoured only when BUSY=0
//  PHASE      in   PHASE_W           phase, sampled on accepted START
//  PROGRAM    in   PROG_W            table select, sampled on accepted START
//  MODE       in   2                 0=FULL, 1=HALF, 2=QUARTER, 3=reserved (treated as FULL)
//  INTERP_EN  in   1                 1=linear interpolation, sampled on accepted START
//  ROM_EN     out  1                 ROM read strobe
//  ROM_ADDR   out  PROG_W+ADDR_W     {PROGRAM, table address}
//  ROM_DATA   in   SAMPLE_W          ROM data, valid the cycle after ROM_EN (1-cycle latency)
//  BUSY       out  1                 lookup in progress (state != IDLE)
//  SAMPLE_OUT out  SAMPLE_W          result register; holds its value between lookups
//  OUT_VALID  out  1                 one-cycle pulse, coincident with SAMPLE_OUT update
// BEHAVIOUR
//  Reset: state IDLE; SAMPLE_OUT, OUT_VALID, BUSY, ROM_EN, ROM_ADDR all 0. Reset mid-lookup aborts
//   the lookup with no OUT_VALID.
//  Index field I = top bits of PHASE: FULL uses ADDR_W bits, HALF ADDR_W+1, QUARTER ADDR_W+2.
//   F = the FRAC_W bits directly below I; lower bits are ignored. M = 2^ADDR_W-1.
//  Mapping of an index to address and invert flag (k = low ADDR_W bits of the index):
//   FULL:    addr=k, no invert.
//   HALF:    h = index MSB; addr = h ? M-k : k; invert = h.
//   QUARTER: {q1,q0} = index top 2 bits; addr = q0 ? M-k : k; invert = q1.
//   An inverted value is (2^SAMPLE_W-1) - d.
//  Neighbour index = I+1, modulo the index-field size (wraps to 0). It goes through the same mapping.
//  Interpolation: s0 and s1 are the mapped samples, and they are signed (SAMPLE_W+1) wide.
//   out = s0 + ((s1-s0)*F >>> FRAC_W), using arithmetic shift (floor).
//   The result always lies within [min(s0,s1), max(s0,s1)], so no saturation is needed.
//   When INTERP_EN=0, out = s0.
//  FSM: IDLE -> RD0 -> CAP0 -> [CAP1 if INTERP_EN] -> CALC -> IDLE.
//   IDLE: accept START and latch the inputs.
//   RD0: ROM_EN=1, ROM_ADDR=addr(I).
//   CAP0: capture s0. If interpolating, also ROM_EN=1, ROM_ADDR=addr(I+1).
//   CAP1: capture s1.
//   CALC: compute; SAMPLE_OUT is written on the edge leaving CALC, and OUT_VALID is high the
//    following cycle.
//  Latency from the edge that samples START to the SAMPLE_OUT update: 3 clocks, or 4 with interpolation.
//  START while BUSY=1 is ignored; it is not queued. A START in the cycle OUT_VALID is high is
//   accepted, giving back-to-back throughput of 4 (or 5) cycles.
//  ROM_EN is low in every state other than RD0 and interpolating CAP0. ROM_ADDR holds its last value.
// TESTING (PHASE_W=16, ADDR_W=6, FRAC_W=8, SAMPLE_W=8; ROM model d[addr]=4*addr, PROGRAM=0)
//  1. HALF, PHASE=16'h8000, INTERP_EN=0 -> ROM_ADDR=63, SAMPLE_OUT=3; OUT_VALID 3 clocks after START.
//  2. QUARTER, PHASE=16'h4100 -> addr 62, out 248; PHASE=16'hC100 -> addr 62, out 7.
//  3. FULL, PHASE=16'h2A00 (I=10, F=8'h80), INTERP_EN=1 -> reads addr 10, 11; out 42;
//     latency 4 clocks.
//  4. Wrap: FULL, I=63, F=8'h80, INTERP_EN=1 -> reads addr 63, 0; s0=252, s1=0; out 126.
//  5. START pulsed while BUSY -> ignored: exactly one OUT_VALID and one ROM sequence.
//     START during OUT_VALID -> accepted.
//  6. Assert RST in CAP1 -> all outputs 0 immediately; no OUT_VALID.
//     A subsequent START completes normally. PROGRAM=7'h55 -> ROM_ADDR[12:6]=7'h55.

Source files
------------

// File: rtl/wave_interp_lookup_if.sv
// Lookup request/result bus plus the wavetable ROM read port of wave_interp_lookup.
// The client (NCO side and ROM model) uses master; the lookup engine uses slave.
interface wave_interp_lookup_if #(
    parameter int PHASE_W  = 16,
    parameter int ADDR_W   = 6,
    parameter int SAMPLE_W = 8,
    parameter int PROG_W   = 7
);
    logic                     START;
    logic [PHASE_W-1:0]       PHASE;
    logic [PROG_W-1:0]        PROGRAM;
    logic [1:0]               MODE;
    logic                     INTERP_EN;
    logic                     ROM_EN;
    logic [PROG_W+ADDR_W-1:0] ROM_ADDR;
    logic [SAMPLE_W-1:0]      ROM_DATA;
    logic                     BUSY;
    logic [SAMPLE_W-1:0]      SAMPLE_OUT;
    logic                     OUT_VALID;

    modport master (
        output START, PHASE, PROGRAM, MODE, INTERP_EN, ROM_DATA,
        input  ROM_EN, ROM_ADDR, BUSY, SAMPLE_OUT, OUT_VALID
    );

    modport slave (
        input  START, PHASE, PROGRAM, MODE, INTERP_EN, ROM_DATA,
        output ROM_EN, ROM_ADDR, BUSY, SAMPLE_OUT, OUT_VALID
    );
endinterface

// File: rtl/wave_interp_lookup.sv
// Phase-to-sample lookup through an external wavetable ROM with full/half/quarter symmetry
// folding and optional linear interpolation between adjacent table points.
module wave_interp_lookup #(
    parameter int PHASE_W  = 16,
    parameter int ADDR_W   = 6,
    parameter int FRAC_W   = 8,
    parameter int SAMPLE_W = 8,
    parameter int PROG_W   = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    wave_interp_lookup_if.slave  bus
);
    localparam int IDX_W   = ADDR_W + 2;
    localparam int SPLIT_W = IDX_W + FRAC_W;
    localparam int PROD_W  = SAMPLE_W + FRAC_W + 3;

    localparam logic [1:0] MODE_HALF    = 2'd1;
    localparam logic [1:0] MODE_QUARTER = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_CAP0 = 3'd2,
        ST_CAP1 = 3'd3,
        ST_CALC = 3'd4
    } state_t;

    // Right-aligns {index, fraction}; the index field is zero-extended to IDX_W bits.
    function automatic logic [SPLIT_W-1:0] split_phase(input logic [1:0] mode,
                                                        input logic [PHASE_W-1:0] phase);
        logic [PHASE_W-1:0] sh_s;
        case (mode)
            MODE_HALF:    sh_s = phase >> (PHASE_W - ADDR_W - 1 - FRAC_W);
            MODE_QUARTER: sh_s = phase >> (PHASE_W - ADDR_W - 2 - FRAC_W);
            default:      sh_s = phase >> (PHASE_W - ADDR_W - FRAC_W);
        endcase
        return sh_s[SPLIT_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] next_index(input logic [1:0] mode,
                                                     input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] inc_s;
        inc_s = idx + {{(IDX_W-1){1'b0}}, 1'b1};
        case (mode)
            MODE_HALF:    return inc_s & {1'b0, {(ADDR_W+1){1'b1}}};
            MODE_QUARTER: return inc_s;
            default:      return inc_s & {2'b00, {ADDR_W{1'b1}}};
        endcase
    endfunction

    // Returns {invert, table address}; M-k is the bitwise complement of k.
    function automatic logic [ADDR_W:0] map_index(input logic [1:0] mode,
                                                   input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] k_s;
        k_s = idx[ADDR_W-1:0];
        case (mode)
            MODE_HALF:    return {idx[ADDR_W], idx[ADDR_W] ? ~k_s : k_s};
            MODE_QUARTER: return {idx[ADDR_W+1], idx[ADDR_W] ? ~k_s : k_s};
            default:      return {1'b0, k_s};
        endcase
    endfunction

    function automatic logic [SAMPLE_W-1:0] apply_invert(input logic inv,
                                                          input logic [SAMPLE_W-1:0] d);
        return inv ? ~d : d;
    endfunction

    state_t                   state_r, next_state_s;
    logic [SPLIT_W-1:0]       split_s;
    logic [IDX_W-1:0]         idx0_s, idx1_s;
    logic [FRAC_W-1:0]        frac_in_s;
    logic [ADDR_W:0]          map0_s, map1_s;
    logic                     accept_s, rom_en_nx_s;
    logic signed [PROD_W-1:0] s0_ext_s, diff_ext_s, frac_ext_s;
    logic [SAMPLE_W-1:0]      lerp_s;

    logic                     rom_en_r, busy_r, out_valid_r;
    logic [PROG_W+ADDR_W-1:0] rom_addr_r;
    logic [SAMPLE_W-1:0]      sample_out_r, s0_r, s1_r;
    logic                     inv0_r, inv1_r, interp_r;
    logic [ADDR_W-1:0]        addr1_r;
    logic [PROG_W-1:0]        prog_r;
    logic [FRAC_W-1:0]        frac_r;

    // Both table points are mapped up front so the CAP0 address is ready one edge early.
    assign split_s     = split_phase(bus.MODE, bus.PHASE);
    assign idx0_s      = split_s[SPLIT_W-1 -: IDX_W];
    assign frac_in_s   = split_s[FRAC_W-1:0];
    assign idx1_s      = next_index(bus.MODE, idx0_s);
    assign map0_s      = map_index(bus.MODE, idx0_s);
    assign map1_s      = map_index(bus.MODE, idx1_s);
    assign accept_s    = (state_r == ST_IDLE) && bus.START;
    assign rom_en_nx_s = (next_state_s == ST_RD0) || ((next_state_s == ST_CAP0) && interp_r);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    next_state_s = ST_RD0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD0: next_state_s = ST_CAP0;
            ST_CAP0: begin
                if (interp_r) begin
                    next_state_s = ST_CAP1;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_CAP1: next_state_s = ST_CALC;
            ST_CALC: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Linear interpolation; the result stays between s0 and s1 so truncation is exact
    always_comb begin
        s0_ext_s   = $signed({{(PROD_W-SAMPLE_W){1'b0}}, s0_r});
        diff_ext_s = $signed({{(PROD_W-SAMPLE_W){1'b0}}, s1_r}) - s0_ext_s;
        frac_ext_s = $signed({{(PROD_W-FRAC_W){1'b0}}, frac_r});
        if (interp_r) begin
            lerp_s = SAMPLE_W'(s0_ext_s + ((diff_ext_s * frac_ext_s) >>> FRAC_W));
        end else begin
            lerp_s = s0_r;
        end
    end

    // Request latching, ROM strobe/address, sample capture and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            rom_addr_r   <= {(PROG_W+ADDR_W){1'b0}};
            sample_out_r <= {SAMPLE_W{1'b0}};
            s0_r         <= {SAMPLE_W{1'b0}};
            s1_r         <= {SAMPLE_W{1'b0}};
            inv0_r       <= 1'b0;
            inv1_r       <= 1'b0;
            interp_r     <= 1'b0;
            addr1_r      <= {ADDR_W{1'b0}};
            prog_r       <= {PROG_W{1'b0}};
            frac_r       <= {FRAC_W{1'b0}};
        end else begin
            rom_en_r    <= rom_en_nx_s;
            busy_r      <= (next_state_s != ST_IDLE);
            out_valid_r <= (state_r == ST_CALC);
            if (accept_s) begin
                rom_addr_r <= {bus.PROGRAM, map0_s[ADDR_W-1:0]};
                inv0_r     <= map0_s[ADDR_W];
                inv1_r     <= map1_s[ADDR_W];
                addr1_r    <= map1_s[ADDR_W-1:0];
                prog_r     <= bus.PROGRAM;
                frac_r     <= frac_in_s;
                interp_r   <= bus.INTERP_EN;
            end else if ((state_r == ST_RD0) && interp_r) begin
                rom_addr_r <= {prog_r, addr1_r};
            end
            if (state_r == ST_CAP0) begin
                s0_r <= apply_invert(inv0_r, bus.ROM_DATA);
            end
            if (state_r == ST_CAP1) begin
                s1_r <= apply_invert(inv1_r, bus.ROM_DATA);
            end
            if (state_r == ST_CALC) begin
                sample_out_r <= lerp_s;
            end
        end
    end

    assign bus.ROM_EN     = rom_en_r;
    assign bus.ROM_ADDR   = rom_addr_r;
    assign bus.BUSY       = busy_r;
    assign bus.SAMPLE_OUT = sample_out_r;
    assign bus.OUT_VALID  = out_valid_r;

endmodule

// File: tb/tb_wave_interp_lookup.sv
// Directed-vector bench for wave_interp_lookup with a queue scoreboard and an
// independent OUT_VALID monitor; ROM model returns d[addr] = 4*addr.
module tb_wave_interp_lookup;
    localparam int PHASE_W  = 16;
    localparam int ADDR_W   = 6;
    localparam int FRAC_W   = 8;
    localparam int SAMPLE_W = 8;
    localparam int PROG_W   = 7;
    localparam logic [1:0] M_FULL = 2'd0;
    localparam logic [1:0] M_HALF = 2'd1;
    localparam logic [1:0] M_QUAR = 2'd2;
    localparam logic [1:0] M_RSVD = 2'd3;

    typedef struct {
        logic [7:0]  smp;
        int          lat;
        int          acc;
        logic [12:0] a0;
        logic [12:0] a1;
        bit          ip;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [12:0] rom_log[$];

    wave_interp_lookup_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W),
                            .PROG_W(PROG_W)) bus();

    wave_interp_lookup #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W),
                         .SAMPLE_W(SAMPLE_W), .PROG_W(PROG_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Wavetable ROM: one-cycle read latency, every read logged for sequence checks
    always @(posedge CLK) begin
        if (bus.ROM_EN === 1'b1) begin
            bus.ROM_DATA <= {bus.ROM_ADDR[5:0], 2'b00};
            rom_log.push_back(bus.ROM_ADDR);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every OUT_VALID pulse is matched against the oldest expected result
    always @(negedge CLK) begin
        if (!RST && bus.OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", bus.OUT_VALID, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample_out", bus.SAMPLE_OUT, mon_e.smp);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
                chk("rom_reads", rom_log.size(), mon_e.ip ? 2 : 1);
                if (rom_log.size() > 0) chk("rom_addr0", rom_log[0], mon_e.a0);
                if (mon_e.ip && rom_log.size() > 1) chk("rom_addr1", rom_log[1], mon_e.a1);
            end
            rom_log.delete();
        end
    end

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic drive(input logic [1:0] md, input logic [15:0] ph, input logic ip,
                         input logic [6:0] pg, input bit push, input logic [7:0] smp,
                         input logic [5:0] a0, input logic [5:0] a1);
        exp_t e;
        bus.MODE      = md;
        bus.PHASE     = ph;
        bus.INTERP_EN = ip;
        bus.PROGRAM   = pg;
        bus.START     = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        if (push) begin
            e.smp = smp;
            e.lat = ip ? 4 : 3;
            e.acc = cyc;
            e.a0  = {pg, a0};
            e.a1  = {pg, a1};
            e.ip  = ip;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.OUT_VALID === 1'b1) break;
        end
        chk("out_valid_seen", bus.OUT_VALID, 1'b1);
    endtask

    task automatic run(input logic [1:0] md, input logic [15:0] ph, input logic ip,
                       input logic [6:0] pg, input logic [7:0] smp,
                       input logic [5:0] a0, input logic [5:0] a1);
        drive(md, ph, ip, pg, 1'b1, smp, a0, a1);
        wait_valid();
        @(negedge CLK);
    endtask

    initial begin
        bus.START     = 1'b0;
        bus.MODE      = M_FULL;
        bus.PHASE     = 16'h0000;
        bus.PROGRAM   = 7'h00;
        bus.INTERP_EN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_sample_out", bus.SAMPLE_OUT, 8'd0);
        chk("reset_out_valid", bus.OUT_VALID, 1'b0);
        chk("reset_busy", bus.BUSY, 1'b0);
        chk("reset_rom_en", bus.ROM_EN, 1'b0);
        chk("reset_rom_addr", bus.ROM_ADDR, 13'd0);
        RST = 1'b0;
        @(negedge CLK);

        run(M_HALF, 16'h8000, 1'b0, 7'h00, 8'd3,   6'd63, 6'd0);
        run(M_QUAR, 16'h4100, 1'b0, 7'h00, 8'd248, 6'd62, 6'd0);
        run(M_QUAR, 16'hC100, 1'b0, 7'h00, 8'd7,   6'd62, 6'd0);
        run(M_FULL, 16'h2A00, 1'b1, 7'h00, 8'd42,  6'd10, 6'd11);
        run(M_FULL, 16'hFE00, 1'b1, 7'h00, 8'd126, 6'd63, 6'd0);
        // HALF boundary: I=63 -> 64 crosses into the inverted half; floor on a negative slope
        run(M_HALF, 16'h7F80, 1'b1, 7'h00, 8'd65,  6'd63, 6'd63);
        run(M_RSVD, 16'h0C00, 1'b0, 7'h00, 8'd12,  6'd3,  6'd0);

        // START while busy is dropped; START during OUT_VALID is taken
        drive(M_FULL, 16'h0400, 1'b0, 7'h00, 1'b1, 8'd4, 6'd1, 6'd0);
        bus.PHASE = 16'h8000;
        bus.START = 1'b1;
        chk("busy_in_rd0", bus.BUSY, 1'b1);
        @(negedge CLK);
        bus.START = 1'b0;
        wait_valid();
        drive(M_FULL, 16'h0800, 1'b0, 7'h00, 1'b1, 8'd8, 6'd2, 6'd0);
        wait_valid();
        @(negedge CLK);

        // Reset asserted while in CAP1 aborts the lookup
        drive(M_FULL, 16'h2A00, 1'b1, 7'h00, 1'b0, 8'd0, 6'd10, 6'd11);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("busy_in_cap1", bus.BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("rst_sample_out", bus.SAMPLE_OUT, 8'd0);
        chk("rst_out_valid", bus.OUT_VALID, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_rom_en", bus.ROM_EN, 1'b0);
        chk("rst_rom_addr", bus.ROM_ADDR, 13'd0);
        @(negedge CLK);
        RST = 1'b0;
        rom_log.delete();
        repeat (8) @(negedge CLK);

        run(M_FULL, 16'h1400, 1'b0, 7'h55, 8'd20, 6'd5, 6'd0);
        chk("rom_addr_program", bus.ROM_ADDR[12:6], 7'h55);

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (8) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
